// File: rtl/amp_frame_sequencer.sv
// amp_frame_sequencer: feeds amplitude frames to the preprocessor one at a time,
// with a one-frame pending slot, a done watchdog and a registered result stage.
module amp_frame_sequencer #(
  parameter int W       = 5,
  parameter int D       = 11,
  parameter int BIN_QTY = 12,
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 16
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [BIN_QTY*(W+D)-1:0]          in_amps,
  output logic [BIN_QTY*(W+D)-1:0]          pp_amps,
  output logic                              pp_start,
  input  logic                              pp_data_v,
  input  logic [BIN_QTY*(W+D)-1:0]          pp_amps_r,
  input  logic [BIN_QTY*(W+D)-1:0]          pp_amps_fast,
  input  logic [W+D+$clog2(BIN_QTY)-1:0]    pp_sum,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [BIN_QTY*(W+D)-1:0]          out_amps,
  output logic [BIN_QTY*(W+D)-1:0]          out_amps_fast,
  output logic [W+D+$clog2(BIN_QTY)-1:0]    out_sum,
  output logic                              busy,
  output logic                              err_timeout,
  output logic [CNT_W-1:0]                  frame_count,
  output logic [CNT_W-1:0]                  drop_count
);

  localparam int FW  = BIN_QTY * (W + D);
  localparam int SW  = W + D + $clog2(BIN_QTY);
  localparam int WDW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT,
    S_OUT
  } state_e;

  state_e           state_q, state_d;
  logic [FW-1:0]    cur_q, cur_d;
  logic [FW-1:0]    pend_q, pend_d;
  logic             pend_v_q, pend_v_d;
  logic [WDW-1:0]   wdog_q, wdog_d;
  logic [FW-1:0]    oamp_q, oamp_d;
  logic [FW-1:0]    ofast_q, ofast_d;
  logic [SW-1:0]    osum_q, osum_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] fcnt_q, fcnt_d;
  logic [CNT_W-1:0] dcnt_q, dcnt_d;
  logic             accept;
  logic             direct;

  assign in_ready      = !pend_v_q;
  assign accept        = in_valid && in_ready;
  assign pp_amps       = cur_q;
  assign pp_start      = (state_q == S_LAUNCH);
  assign out_valid     = (state_q == S_OUT);
  assign busy          = (state_q != S_IDLE);
  assign out_amps      = oamp_q;
  assign out_amps_fast = ofast_q;
  assign out_sum       = osum_q;
  assign err_timeout   = err_q;
  assign frame_count   = fcnt_q;
  assign drop_count    = dcnt_q;

  always_comb begin
    state_d  = state_q;
    cur_d    = cur_q;
    pend_d   = pend_q;
    pend_v_d = pend_v_q;
    wdog_d   = wdog_q;
    oamp_d   = oamp_q;
    ofast_d  = ofast_q;
    osum_d   = osum_q;
    err_d    = err_q;
    fcnt_d   = fcnt_q;
    dcnt_d   = dcnt_q;
    direct   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (pend_v_q) begin
          cur_d    = pend_q;
          pend_v_d = 1'b0;
          state_d  = S_LAUNCH;
        end else if (accept) begin
          cur_d   = in_amps;
          direct  = 1'b1;
          state_d = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        wdog_d  = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        wdog_d = wdog_q + 1'b1;
        // A result on the final watchdog cycle still counts as on time.
        if (pp_data_v) begin
          oamp_d  = pp_amps_r;
          ofast_d = pp_amps_fast;
          osum_d  = pp_sum;
          state_d = S_OUT;
        end else if (wdog_q == WDW'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          dcnt_d  = dcnt_q + 1'b1;
          state_d = S_IDLE;
        end
      end
      S_OUT: begin
        if (out_ready) begin
          fcnt_d = fcnt_q + 1'b1;
          if (pend_v_q) begin
            cur_d    = pend_q;
            pend_v_d = 1'b0;
            state_d  = S_LAUNCH;
          end else if (accept) begin
            cur_d   = in_amps;
            direct  = 1'b1;
            state_d = S_LAUNCH;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (accept && !direct) begin
      pend_d   = in_amps;
      pend_v_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cur_q    <= '0;
      pend_q   <= '0;
      pend_v_q <= 1'b0;
      wdog_q   <= '0;
      oamp_q   <= '0;
      ofast_q  <= '0;
      osum_q   <= '0;
      err_q    <= 1'b0;
      fcnt_q   <= '0;
      dcnt_q   <= '0;
    end else begin
      state_q  <= state_d;
      cur_q    <= cur_d;
      pend_q   <= pend_d;
      pend_v_q <= pend_v_d;
      wdog_q   <= wdog_d;
      oamp_q   <= oamp_d;
      ofast_q  <= ofast_d;
      osum_q   <= osum_d;
      err_q    <= err_d;
      fcnt_q   <= fcnt_d;
      dcnt_q   <= dcnt_d;
    end
  end

endmodule

// File: tb/tb_amp_frame_sequencer.sv
// tb_amp_frame_sequencer: scoreboard bench with a behavioural preprocessor
// (result = 0.9 * bin, fast = bin, sum of reduced bins).
module tb_amp_frame_sequencer;

  localparam int W       = 5;
  localparam int D       = 11;
  localparam int BQ      = 12;
  localparam int TIMEOUT = 15;
  localparam int CNT_W   = 16;
  localparam int AW      = W + D;
  localparam int FW      = BQ * AW;
  localparam int SW      = AW + $clog2(BQ);

  typedef struct packed {
    logic [FW-1:0] r;
    logic [FW-1:0] f;
    logic [SW-1:0] s;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [FW-1:0]     in_amps = '0;
  logic [FW-1:0]     pp_amps;
  logic              pp_start;
  logic              pp_data_v = 1'b0;
  logic [FW-1:0]     pp_amps_r = '0;
  logic [FW-1:0]     pp_amps_fast = '0;
  logic [SW-1:0]     pp_sum = '0;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic [FW-1:0]     out_amps;
  logic [FW-1:0]     out_amps_fast;
  logic [SW-1:0]     out_sum;
  logic              busy;
  logic              err_timeout;
  logic [CNT_W-1:0]  frame_count;
  logic [CNT_W-1:0]  drop_count;

  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   acc_cyc = 0;
  int   exp_frames = 0;
  int   lat = 4;
  bit   rand_lat = 0;
  bit   rand_bp = 0;
  bit   or_man = 1;
  bit   stray = 0;
  exp_t sb[$];
  int   hs_q[$];

  amp_frame_sequencer #(
    .W(W), .D(D), .BIN_QTY(BQ), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_amps(in_amps),
    .pp_amps(pp_amps), .pp_start(pp_start), .pp_data_v(pp_data_v),
    .pp_amps_r(pp_amps_r), .pp_amps_fast(pp_amps_fast), .pp_sum(pp_sum),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_amps(out_amps), .out_amps_fast(out_amps_fast), .out_sum(out_sum),
    .busy(busy), .err_timeout(err_timeout),
    .frame_count(frame_count), .drop_count(drop_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  always @(posedge clk) begin
    #2;
    out_ready = rand_bp ? 1'($urandom_range(0, 1)) : or_man;
  end

  function automatic exp_t model(input logic [FW-1:0] x);
    exp_t e;
    int unsigned v;
    int unsigned t;
    e.f = x;
    e.r = '0;
    e.s = '0;
    for (int i = 0; i < BQ; i++) begin
      v = 32'(x[i*AW +: AW]);
      t = v * 9 / 10;
      e.r[i*AW +: AW] = AW'(t);
      e.s = e.s + SW'(t);
    end
    return e;
  endfunction

  function automatic logic [FW-1:0] rnd();
    logic [FW-1:0] x;
    for (int i = 0; i < BQ; i++) x[i*AW +: AW] = AW'($urandom);
    return x;
  endfunction

  task automatic chk(input string nm, input logic [511:0] act,
                     input logic [511:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h required %0h", nm, act, req);
    end
  endtask

  // Preprocessor: samples its input at start and again when it answers.
  int            k = 0;
  logic [FW-1:0] snap = '0;
  always @(negedge clk) begin
    exp_t e;
    pp_data_v = 1'b0;
    if (rst) begin
      k = 0;
    end else if (stray) begin
      pp_data_v    = 1'b1;
      pp_amps_r    = {6{$urandom}};
      pp_amps_fast = {6{$urandom}};
      pp_sum       = SW'($urandom);
    end else if (pp_start) begin
      snap = pp_amps;
      k = rand_lat ? int'($urandom_range(1, TIMEOUT)) : lat;
    end else if (k > 0) begin
      k--;
      if (k == 0) begin
        e = model(snap);
        pp_data_v    = 1'b1;
        pp_amps_r    = e.r;
        pp_amps_fast = pp_amps;
        pp_sum       = e.s;
      end
    end
  end

  // Monitor: pops the scoreboard on each output handshake.
  bit                   hold_v = 0;
  logic [2*FW+SW-1:0]   held = '0;
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      sb.delete();
      hold_v = 0;
      exp_frames = 0;
    end else begin
      if (out_valid && hold_v)
        chk("out_stable", 512'({out_amps, out_amps_fast, out_sum}),
            512'(held));
      hold_v = out_valid && !out_ready;
      held = {out_amps, out_amps_fast, out_sum};
      if (out_valid && out_ready) begin
        hs_q.push_back(cyc);
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_output: got %0h required none",
                   out_sum);
        end else begin
          e = sb.pop_front();
          chk("out_amps", 512'(out_amps), 512'(e.r));
          chk("out_amps_fast", 512'(out_amps_fast), 512'(e.f));
          chk("out_sum", 512'(out_sum), 512'(e.s));
          exp_frames++;
        end
      end
    end
  end

  task automatic send(input logic [FW-1:0] f, input bit push,
                      input bit keep);
    int t = 0;
    @(negedge clk);
    in_amps = f;
    in_valid = 1'b1;
    while (!in_ready && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      tests++;
      fails++;
      $display("FAIL send_accept: got in_ready=0 required 1");
    end
    @(posedge clk);
    #1;
    acc_cyc = cyc;
    if (push && t < 300) sb.push_back(model(f));
    if (!keep) in_valid = 1'b0;
  endtask

  task automatic wait_empty(input string nm);
    int t = 0;
    while (sb.size() != 0 && t < 2000) begin
      @(negedge clk);
      t++;
    end
    chk(nm, 512'(sb.size()), 512'(0));
    @(negedge clk);
  endtask

  task automatic pulse_rst();
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic check_reset(input string nm);
    chk({nm, "_in_ready"}, 512'(in_ready), 512'(1));
    chk({nm, "_pp_start"}, 512'(pp_start), 512'(0));
    chk({nm, "_out_valid"}, 512'(out_valid), 512'(0));
    chk({nm, "_busy"}, 512'(busy), 512'(0));
    chk({nm, "_err"}, 512'(err_timeout), 512'(0));
    chk({nm, "_fcnt"}, 512'(frame_count), 512'(0));
    chk({nm, "_dcnt"}, 512'(drop_count), 512'(0));
    chk({nm, "_pp_amps"}, 512'(pp_amps), 512'(0));
    chk({nm, "_out_data"}, 512'({out_amps, out_amps_fast, out_sum}),
        512'(0));
  endtask

  initial begin
    logic [FW-1:0] f;
    logic [FW-1:0] f2;
    logic [FW-1:0] f3;
    int t;
    int n;
    int bad;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_reset("reset");

    // Single frame with 4.0 in bin 0.
    f = '0;
    f[AW-1:0] = AW'(8192);
    chk("model_bin0", 512'(model(f).r[AW-1:0]), 512'(7372));
    send(f, 1, 0);
    @(negedge clk);
    t = 0;
    while (!pp_start && t < 50) begin @(negedge clk); t++; end
    chk("start_latency", 512'(cyc), 512'(acc_cyc));
    while (!out_valid && t < 50) begin @(negedge clk); t++; end
    chk("out_latency", 512'(cyc), 512'(acc_cyc + 5));
    wait_empty("single_drain");
    chk("single_fcnt", 512'(frame_count), 512'(1));

    // Result on the very last watchdog cycle.
    lat = TIMEOUT;
    send(rnd(), 1, 0);
    wait_empty("lastwait_drain");
    chk("lastwait_err", 512'(err_timeout), 512'(0));
    chk("lastwait_dcnt", 512'(drop_count), 512'(0));
    lat = 4;

    // Backpressure with a pending frame and a refused third.
    or_man = 0;
    f2 = rnd();
    f3 = rnd();
    send(rnd(), 1, 0);
    t = 0;
    while (!out_valid && t < 50) begin @(negedge clk); t++; end
    send(f2, 1, 1);
    @(negedge clk);
    chk("bp_pending_full", 512'(in_ready), 512'(0));
    in_amps = f3;
    sb.push_back(model(f3));
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (in_ready || !out_valid) bad++;
    end
    chk("bp_refuse_hold", 512'(bad), 512'(0));
    @(posedge clk);
    #1 or_man = 1;
    @(posedge clk);
    @(negedge clk);
    chk("bp_relaunch", 512'(pp_start), 512'(1));
    chk("bp_relaunch_amps", 512'(pp_amps), 512'(f2));
    @(posedge clk);
    #1 in_valid = 1'b0;
    wait_empty("bp_drain");
    chk("bp_fcnt", 512'(frame_count), 512'(CNT_W'(exp_frames)));

    // Random frames, latencies and backpressure.
    rand_bp = 1;
    rand_lat = 1;
    for (int i = 0; i < 30; i++) begin
      send(rnd(), 1, 0);
      repeat ($urandom_range(0, 8)) @(negedge clk);
    end
    wait_empty("rand_drain");
    rand_bp = 0;
    rand_lat = 0;
    chk("rand_fcnt", 512'(frame_count), 512'(CNT_W'(exp_frames)));
    chk("rand_dcnt", 512'(drop_count), 512'(0));

    // Reset mid-WAIT with a frame pending, then a stray done pulse.
    send(rnd(), 1, 0);
    send(rnd(), 1, 0);
    pulse_rst();
    check_reset("rst_wait");
    @(posedge clk);
    #1 stray = 1;
    @(posedge clk);
    #1 stray = 0;
    @(negedge clk);
    chk("stray_valid", 512'(out_valid), 512'(0));
    chk("stray_busy", 512'(busy), 512'(0));
    chk("stray_data", 512'({out_amps, out_sum}), 512'(0));

    // Reset while holding a result.
    or_man = 0;
    send(rnd(), 1, 0);
    t = 0;
    while (!out_valid && t < 50) begin @(negedge clk); t++; end
    chk("rst_out_reached", 512'(out_valid), 512'(1));
    pulse_rst();
    check_reset("rst_out");
    or_man = 1;

    // Streaming with both handshakes held high.
    @(posedge clk);
    #3 hs_q.delete();
    for (int i = 0; i < 10; i++) send(rnd(), 1, 1);
    in_valid = 1'b0;
    wait_empty("stream_drain");
    chk("stream_outs", 512'(hs_q.size()), 512'(10));
    for (int i = 1; i < hs_q.size(); i++)
      chk("stream_spacing", 512'(hs_q[i] - hs_q[i-1]), 512'(6));
    chk("stream_fcnt", 512'(frame_count), 512'(10));
    chk("stream_dcnt", 512'(drop_count), 512'(0));

    // Watchdog: the preprocessor never answers.
    lat = 0;
    send(rnd(), 0, 0);
    @(negedge clk);
    t = 0;
    while (!pp_start && t < 50) begin @(negedge clk); t++; end
    @(negedge clk);
    n = 0;
    while (busy && n < 100) begin @(negedge clk); n++; end
    chk("to_wait_cycles", 512'(n), 512'(TIMEOUT));
    chk("to_err", 512'(err_timeout), 512'(1));
    chk("to_dcnt", 512'(drop_count), 512'(1));
    chk("to_busy", 512'(busy), 512'(0));
    lat = 4;
    send(rnd(), 1, 0);
    wait_empty("to_next_drain");
    chk("to_next_fcnt", 512'(frame_count), 512'(11));
    chk("to_err_sticky", 512'(err_timeout), 512'(1));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/amp_frame_sequencer.md
Name: amp_frame_sequencer

Overview:
Sequences note-amplitude frames through the amplitude preprocessor stage. It accepts frames from the upstream bin-magnitude producer over a valid/ready handshake and holds each frame stable on the preprocessor input. It pulses the preprocessor start, waits for its done flag with a watchdog, captures the filtered results, and presents them to the downstream visualizer over a second valid/ready handshake. A one-frame pending buffer lets the producer hand over the next frame while the current one is in flight.

Parameters:
W, 5, whole bits of the fixed-point amplitude format
D, 11, fractional bits of the fixed-point amplitude format
BIN_QTY, 12, number of amplitude bins per frame
TIMEOUT, 15, WAIT-state cycles without pp_data_v before the frame is abandoned (must be > 4)
CNT_W, 16, width of the frame and drop counters

Ports:
clk  input  1  clock
rst  input  1  synchronous, active-high reset
in_valid  input  1  upstream frame valid
in_ready  output  1  sequencer can accept a frame
in_amps  input  BIN_QTY*(W+D)  upstream frame, bin i at [i*(W+D) +: W+D]
pp_amps  output  BIN_QTY*(W+D)  frame driven to the preprocessor, held stable
pp_start  output  1  one-cycle start pulse to the preprocessor
pp_data_v  input  1  preprocessor done
pp_amps_r  input  BIN_QTY*(W+D)  preprocessor reduced/filtered amplitudes
pp_amps_fast  input  BIN_QTY*(W+D)  preprocessor filtered, unreduced amplitudes
pp_sum  input  W+D+$clog2(BIN_QTY)  preprocessor sum of reduced amplitudes
out_valid  output  1  result valid to downstream
out_ready  input  1  downstream accepts result
out_amps, out_amps_fast, out_sum  output  same widths as pp_*  registered results
busy  output  1  state != IDLE
err_timeout  output  1  sticky watchdog error flag
frame_count  output  CNT_W  frames delivered downstream
drop_count  output  CNT_W  frames abandoned on timeout

Behaviour:
- Reset: state=IDLE; pending empty; pp_start=0; out_valid=0; err_timeout=0; both counters=0; pp_amps and out_* data=0; in_ready=1 on the first cycle after reset. Reset mid-operation aborts everything. A later stray pp_data_v is ignored in any state other than WAIT.
- in_ready = !pending_valid (combinational from registers). An accept occurs when in_valid & in_ready.
- States:
  - IDLE: accept -> load cur (drives pp_amps), go to LAUNCH. If pending_valid, move pending -> cur, clear pending, go to LAUNCH.
  - LAUNCH: pp_start=1 for exactly this cycle; clear wdog; go to WAIT.
  - WAIT: wdog++ each cycle. If pp_data_v, register pp_amps_r/pp_amps_fast/pp_sum into out_*, go to OUT. Else if wdog==TIMEOUT-1, set err_timeout, drop_count++, go to IDLE (frame discarded).
  - OUT: out_valid=1, out_* stable. When out_ready: frame_count++; if pending_valid (or an accept this cycle), move it to cur and go to LAUNCH; else go to IDLE.
- Accepts in LAUNCH/WAIT/OUT write the pending buffer. Accepts in IDLE, or in OUT while out_ready moves the frame straight to cur, bypass pending.
- pp_amps changes only on the transition into LAUNCH. It is held through WAIT, because the preprocessor samples its input in two different cycles.
- Latency with the standard 4-cycle preprocessor:
  - accept at edge N -> pp_start high in cycle N+1 -> pp_data_v in cycle N+5 -> out_valid high from cycle N+6.
  - Back-to-back throughput with out_ready tied high: one frame per 6 cycles.
- Counters wrap at 2^CNT_W. err_timeout clears only on rst.
- Simultaneous pp_data_v on the timeout cycle: data wins (no error).
- Pending full: in_ready=0; the producer must stall. No frame is ever overwritten.

Test Plan:
- Single frame: after reset, bin0=8192 (4.0), others 0, in_valid 1 cycle with a real preprocessor -> pp_start one cycle later; out_valid 5 cycles after pp_start with out_amps bin0=7372, out_amps_fast bin0=8192, out_sum=7372, frame_count=1.
- Backpressure: out_ready=0 for 20 cycles -> out_valid held, out_* stable. A second frame is accepted into pending, then in_ready=0 and a third is refused. Release out_ready -> second frame launches next cycle; no frame lost.
- Timeout: stub never asserts pp_data_v -> exactly TIMEOUT WAIT cycles, then err_timeout=1, drop_count=1, busy=0. The next frame still completes normally.
- Data on the last WAIT cycle: pp_data_v exactly at wdog==TIMEOUT-1 -> result delivered, err_timeout stays 0.
- Reset mid-WAIT and mid-OUT: rst for 1 cycle -> all outputs return to reset values, pending cleared. A stray pp_data_v afterwards is ignored.
- Streaming: 10 frames with in_valid and out_ready held high -> 10 outputs in order, 6-cycle spacing, frame_count=10, drop_count=0.
